// File: rtl/orion_mem_pkg.sv
// orion_mem_pkg: shared types and constants for the Orion-PRO main-RAM arbiter.
//   state_t   : sequencer states (idle / access / done)
//   grant_t   : which requester owns the current RAM access
//   ACC_CNT_W : width of the access-cycle and video-burst counters
package orion_mem_pkg;

  localparam int ACC_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VID,
    GNT_CPU,
    GNT_LDR
  } grant_t;

endpackage

// File: rtl/orion_mem_pick.sv
// orion_mem_pick: combinational grant selector for the main-RAM arbiter.
//   vid_req_i    : video request (highest priority)
//   cpu_req_i    : CPU request
//   ldr_req_i    : loader/debug request
//   rr_ldr_i     : 1 = loader wins a CPU/loader tie, 0 = CPU wins
//   burst_full_i : video has used up its consecutive-grant allowance
//   gnt_o        : selected requester, GNT_NONE when nobody asks
module orion_mem_pick
  import orion_mem_pkg::*;
(
  input  logic   vid_req_i,
  input  logic   cpu_req_i,
  input  logic   ldr_req_i,
  input  logic   rr_ldr_i,
  input  logic   burst_full_i,
  output grant_t gnt_o
);

  logic other_req;
  assign other_req = cpu_req_i | ldr_req_i;

  always_comb begin
    gnt_o = GNT_NONE;
    // Video only yields once its burst allowance is spent and someone else waits.
    if (vid_req_i && !(burst_full_i && other_req)) gnt_o = GNT_VID;
    else if (cpu_req_i && ldr_req_i)               gnt_o = rr_ldr_i ? GNT_LDR : GNT_CPU;
    else if (cpu_req_i)                            gnt_o = GNT_CPU;
    else if (ldr_req_i)                            gnt_o = GNT_LDR;
  end

endmodule

// File: rtl/orion_mem_arbiter.sv
// orion_mem_arbiter: arbiter and access sequencer for the single 8-bit main RAM.
// Serves video (read-only, priority), Z80 CPU and loader; one fixed-length
// access at a time: IDLE (arbitrate) -> ACCESS (ACCESS_CYCLES) -> DONE (ack).
//   i_clk / i_reset_n      : clock, synchronous active-low reset
//   i_vid_* / o_vid_*      : video read port (req level, ack pulse + rdata)
//   i_cpu_* / o_cpu_*      : CPU port, o_cpu_wait drives Z80 WAIT
//   i_ldr_* / o_ldr_*      : loader/debug port
//   o_mem_* / i_mem_rdata  : RAM strobes, address, write data, read data
module orion_mem_arbiter
  import orion_mem_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VID_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_ack,
  output logic [7:0]        o_vid_rdata,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_wait,
  input  logic              i_ldr_req,
  input  logic              i_ldr_we,
  input  logic [ADDR_W-1:0] i_ldr_addr,
  input  logic [7:0]        i_ldr_wdata,
  output logic              o_ldr_ack,
  output logic [7:0]        o_ldr_rdata,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata
);

  localparam logic [ACC_CNT_W-1:0] ACC_LAST  = ACC_CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [ACC_CNT_W-1:0] BURST_MAX = ACC_CNT_W'(MAX_VID_BURST);

  state_t               state_q;
  grant_t               gnt_q;
  logic                 rr_ldr_q;
  logic [ACC_CNT_W-1:0] acc_cnt_q;
  logic [ACC_CNT_W-1:0] burst_q, burst_d;
  logic                 mem_cs_q, mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic                 vid_ack_q, cpu_ack_q, ldr_ack_q;
  logic [7:0]           vid_rdata_q, cpu_rdata_q, ldr_rdata_q;

  grant_t               pick_gnt;
  logic                 other_req;
  logic                 burst_full;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [7:0]           sel_wdata;

  assign other_req  = i_cpu_req | i_ldr_req;
  assign burst_full = (burst_q == BURST_MAX);

  orion_mem_pick u_pick (
    .vid_req_i    (i_vid_req),
    .cpu_req_i    (i_cpu_req),
    .ldr_req_i    (i_ldr_req),
    .rr_ldr_i     (rr_ldr_q),
    .burst_full_i (burst_full),
    .gnt_o        (pick_gnt)
  );

  // Request mux and next burst count for the candidate grant.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = mem_addr_q;
    sel_wdata = mem_wdata_q;
    burst_d   = burst_q;
    case (pick_gnt)
      GNT_VID: begin
        sel_addr = i_vid_addr;
        // Only video grants that make someone else wait count toward the burst.
        if (!other_req)       burst_d = '0;
        else if (!burst_full) burst_d = burst_q + 1'b1;
      end
      GNT_CPU: begin
        sel_we    = i_cpu_we;
        sel_addr  = i_cpu_addr;
        sel_wdata = i_cpu_wdata;
        burst_d   = '0;
      end
      GNT_LDR: begin
        sel_we    = i_ldr_we;
        sel_addr  = i_ldr_addr;
        sel_wdata = i_ldr_wdata;
        burst_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_NONE;
      rr_ldr_q    <= 1'b0;
      acc_cnt_q   <= '0;
      burst_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_gnt != GNT_NONE) begin
            gnt_q       <= pick_gnt;
            mem_cs_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            acc_cnt_q   <= '0;
            burst_q     <= burst_d;
            // Video grants leave the CPU/loader round-robin untouched.
            if (pick_gnt == GNT_CPU) rr_ldr_q <= 1'b1;
            if (pick_gnt == GNT_LDR) rr_ldr_q <= 1'b0;
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (acc_cnt_q == ACC_LAST) begin
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Read data is captured even for writes' owners only on reads.
            case (gnt_q)
              GNT_VID: begin
                vid_ack_q   <= 1'b1;
                vid_rdata_q <= i_mem_rdata;
              end
              GNT_CPU: begin
                cpu_ack_q <= 1'b1;
                if (!mem_we_q) cpu_rdata_q <= i_mem_rdata;
              end
              GNT_LDR: begin
                ldr_ack_q <= 1'b1;
                if (!mem_we_q) ldr_rdata_q <= i_mem_rdata;
              end
              default: ;
            endcase
            state_q <= ST_DONE;
          end else begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_vid_ack   = vid_ack_q;
  assign o_vid_rdata = vid_rdata_q;
  assign o_cpu_ack   = cpu_ack_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_cpu_wait  = i_cpu_req & ~cpu_ack_q;
  assign o_ldr_ack   = ldr_ack_q;
  assign o_ldr_rdata = ldr_rdata_q;
  assign o_mem_cs    = mem_cs_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_orion_mem_arbiter.sv
module tb_orion_mem_arbiter;

  localparam int AW  = 20;
  localparam int AC  = 2;
  localparam int MVB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vid_req = 0, cpu_req = 0, ldr_req = 0;
  logic          cpu_we = 0, ldr_we = 0;
  logic [AW-1:0] vid_addr = '0, cpu_addr = '0, ldr_addr = '0;
  logic [7:0]    cpu_wdata = '0, ldr_wdata = '0;
  logic          vid_ack, cpu_ack, ldr_ack, cpu_wait;
  logic [7:0]    vid_rdata, cpu_rdata, ldr_rdata;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  logic          use_ram = 1'b0;
  logic          ram_clr = 1'b0;
  logic [7:0]    mem_rd_drv = '0;
  logic [7:0]    ram [256];
  logic [7:0]    ref_mem [256];

  always #5 clk = ~clk;

  orion_mem_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC), .MAX_VID_BURST(MVB)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_ack(vid_ack), .o_vid_rdata(vid_rdata),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_wait(cpu_wait),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .o_ldr_ack(ldr_ack), .o_ldr_rdata(ldr_rdata),
    .o_mem_cs(mem_cs), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Simple RAM behind the arbiter, used by the random phase.
  assign mem_rdata = use_ram ? ram[mem_addr[7:0]] : mem_rd_drv;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 5);
    end else if (mem_cs && mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rd_of(input int s);
    return (s == 0) ? vid_rdata : (s == 1) ? cpu_rdata : ldr_rdata;
  endfunction

  function automatic logic [2:0] acks();
    return {ldr_ack, cpu_ack, vid_ack};
  endfunction

  task automatic set_req(input int s, input logic on);
    if (s == 0) vid_req = on;
    else if (s == 1) cpu_req = on;
    else ldr_req = on;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vid_req = 0; cpu_req = 0; ldr_req = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Raise the requests in req_on and record ack order/cycle; requesters in
  // hold keep req high after their ack (new transaction each time).
  task automatic run_collect(input logic [2:0] req_on, input logic [2:0] hold, input int n,
                             output int srcs[16], output int cyc[16]);
    int c, got;
    logic [2:0] a;
    for (int i = 0; i < 16; i++) begin srcs[i] = -1; cyc[i] = -1; end
    vid_req = req_on[0]; cpu_req = req_on[1]; ldr_req = req_on[2];
    c = 0; got = 0;
    while (got < n && c < 80) begin
      @(negedge clk);
      a = acks();
      for (int s = 0; s < 3; s++)
        if (a[s]) begin
          if (got < 16) begin srcs[got] = s; cyc[got] = c; end
          got++;
        end
      tick();
      for (int s = 0; s < 3; s++) if (a[s] && !hold[s]) set_req(s, 1'b0);
      c++;
    end
    chk("collect_ack_count", 32'(got), 32'(n));
    vid_req = 0; cpu_req = 0; ldr_req = 0;
  endtask

  typedef struct {
    int         src;
    logic       we;
    logic [19:0] addr;
    logic [7:0] wdata;
    logic [7:0] mrd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt[7];
  int   t_src[16], t_cyc[16];
  int   exp_src[6], exp_cyc[6];

  // Random-phase reference model state
  logic        act[3];
  logic        rw[3];
  logic [19:0] ra[3];
  logic [7:0]  rdt[3];
  logic [7:0]  exp_rd[3];

  initial begin
    int streak, free_at, g_at, g_src, win;
    logic prefer_ldr, g_we, other, in_acc, ackc;
    logic [19:0] g_a;
    logic [7:0] g_d;

    vt[0] = '{1, 1'b0, 20'h01234, 8'h00, 8'hA5, 8'hA5};
    vt[1] = '{2, 1'b1, 20'h7FFFF, 8'h5A, 8'h33, 8'h00};
    vt[2] = '{0, 1'b0, 20'h00010, 8'h00, 8'h3C, 8'h3C};
    vt[3] = '{2, 1'b0, 20'hFFFFF, 8'h00, 8'hC3, 8'hC3};
    vt[4] = '{1, 1'b1, 20'h00000, 8'hFF, 8'h77, 8'hA5};
    vt[5] = '{0, 1'b0, 20'h80000, 8'h00, 8'h00, 8'h00};
    vt[6] = '{2, 1'b1, 20'h12345, 8'h01, 8'h99, 8'hC3};

    // ---- reset state
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_acks", 32'(acks()), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", {8'h0, vid_rdata, cpu_rdata, ldr_rdata}, 32'd0);
    tick();
    rst_n = 1'b1;

    // ---- single-transaction vectors
    for (int v = 0; v < 7; v++) begin
      mem_rd_drv = vt[v].mrd;
      case (vt[v].src)
        0: vid_addr = vt[v].addr;
        1: begin cpu_we = vt[v].we; cpu_addr = vt[v].addr; cpu_wdata = vt[v].wdata; end
        default: begin ldr_we = vt[v].we; ldr_addr = vt[v].addr; ldr_wdata = vt[v].wdata; end
      endcase
      set_req(vt[v].src, 1'b1);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d_c%0d_cs", v, c), 32'(mem_cs), 32'(c == 1 || c == 2));
        if (c == 1 || c == 2) begin
          chk($sformatf("v%0d_c%0d_we", v, c), 32'(mem_we), 32'(vt[v].we));
          chk($sformatf("v%0d_c%0d_addr", v, c), 32'(mem_addr), 32'(vt[v].addr));
          if (vt[v].we) chk($sformatf("v%0d_c%0d_wdata", v, c), 32'(mem_wdata), 32'(vt[v].wdata));
        end else begin
          chk($sformatf("v%0d_c%0d_we", v, c), 32'(mem_we), 32'd0);
        end
        chk($sformatf("v%0d_c%0d_acks", v, c), 32'(acks()), (c == 3) ? (32'd1 << vt[v].src) : 32'd0);
        if (vt[v].src == 1) chk($sformatf("v%0d_c%0d_wait", v, c), 32'(cpu_wait), 32'(c < 3));
        if (c == 3) chk($sformatf("v%0d_rdata", v), 32'(rd_of(vt[v].src)), 32'(vt[v].exp_rd));
        if (c < 3) tick();
      end
      tick();
      set_req(vt[v].src, 1'b0);
    end

    // ---- all three at once: video, CPU, loader
    cpu_we = 0; ldr_we = 0;
    run_collect(3'b111, 3'b000, 3, t_src, t_cyc);
    exp_src[0:2] = '{0, 1, 2};
    exp_cyc[0:2] = '{3, 7, 11};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("all3_src%0d", i), 32'(t_src[i]), 32'(exp_src[i]));
      chk($sformatf("all3_cyc%0d", i), 32'(t_cyc[i]), 32'(exp_cyc[i]));
    end

    // ---- video burst override with CPU pending
    run_collect(3'b011, 3'b001, 6, t_src, t_cyc);
    exp_src = '{0, 0, 0, 0, 1, 0};
    exp_cyc = '{3, 7, 11, 15, 19, 23};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_src%0d", i), 32'(t_src[i]), 32'(exp_src[i]));
      chk($sformatf("burst_cyc%0d", i), 32'(t_cyc[i]), 32'(exp_cyc[i]));
    end

    // ---- CPU/loader round-robin from reset
    do_reset();
    run_collect(3'b110, 3'b110, 4, t_src, t_cyc);
    exp_src[0:3] = '{1, 2, 1, 2};
    exp_cyc[0:3] = '{3, 7, 11, 15};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_src%0d", i), 32'(t_src[i]), 32'(exp_src[i]));
      chk($sformatf("rr_cyc%0d", i), 32'(t_cyc[i]), 32'(exp_cyc[i]));
    end

    // ---- reset during cycle 1 of a CPU write
    cpu_we = 1; cpu_addr = 20'h00ABC; cpu_wdata = 8'h99;
    cpu_req = 1;
    @(negedge clk);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_c1_cs", 32'(mem_cs), 32'd1);
    chk("mid_rst_c1_we", 32'(mem_we), 32'd1);
    tick();
    rst_n = 1'b1;
    cpu_req = 0;
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_c%0d_cs", c), 32'(mem_cs), 32'd0);
      chk($sformatf("mid_rst_c%0d_we", c), 32'(mem_we), 32'd0);
      chk($sformatf("mid_rst_c%0d_acks", c), 32'(acks()), 32'd0);
      tick();
    end
    cpu_we = 0; cpu_addr = 20'h00042; mem_rd_drv = 8'h6E;
    run_collect(3'b010, 3'b000, 1, t_src, t_cyc);
    chk("post_rst_src", 32'(t_src[0]), 32'd1);
    chk("post_rst_cyc", 32'(t_cyc[0]), 32'd3);
    chk("post_rst_rdata", 32'(cpu_rdata), 32'h6E);

    // ---- randomized traffic against a transaction-level model
    ram_clr = 1'b1;
    do_reset();
    ram_clr = 1'b0;
    use_ram = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    for (int s = 0; s < 3; s++) begin act[s] = 0; exp_rd[s] = 8'h00; end
    streak = 0; prefer_ldr = 0; free_at = 0; g_at = -100; g_src = -1;
    g_we = 0; g_a = '0; g_d = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 3; s++)
        if (!act[s] && $urandom_range(0, 2) == 0) begin
          act[s] = 1;
          rw[s]  = (s == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          ra[s]  = 20'($urandom) & 20'hF000F;
          rdt[s] = 8'($urandom);
        end
      vid_req = act[0]; vid_addr = ra[0];
      cpu_req = act[1]; cpu_we = rw[1]; cpu_addr = ra[1]; cpu_wdata = rdt[1];
      ldr_req = act[2]; ldr_we = rw[2]; ldr_addr = ra[2]; ldr_wdata = rdt[2];
      if (c >= free_at) begin
        other = act[1] | act[2];
        if (act[0] && !(streak >= MVB && other)) win = 0;
        else if (act[1] && act[2])               win = prefer_ldr ? 2 : 1;
        else if (act[1])                         win = 1;
        else if (act[2])                         win = 2;
        else                                     win = -1;
        if (win >= 0) begin
          g_src = win; g_at = c; g_we = rw[win]; g_a = ra[win]; g_d = rdt[win];
          free_at = c + AC + 2;
          if (win == 0) streak = other ? ((streak < MVB) ? streak + 1 : streak) : 0;
          else begin streak = 0; prefer_ldr = (win == 1); end
          if (g_we) ref_mem[g_a[7:0]] = g_d;
          else      exp_rd[win] = ref_mem[g_a[7:0]];
        end
      end
      @(negedge clk);
      in_acc = (g_src >= 0) && (c > g_at) && (c <= g_at + AC);
      ackc   = (g_src >= 0) && (c == g_at + AC + 1);
      chk("rnd_cs", 32'(mem_cs), 32'(in_acc));
      if (in_acc) begin
        chk("rnd_we", 32'(mem_we), 32'(g_we));
        chk("rnd_addr", 32'(mem_addr), 32'(g_a));
        if (g_we) chk("rnd_wdata", 32'(mem_wdata), 32'(g_d));
      end
      chk("rnd_acks", 32'(acks()), ackc ? (32'd1 << g_src) : 32'd0);
      chk("rnd_wait", 32'(cpu_wait), 32'(act[1] && !(ackc && g_src == 1)));
      if (ackc) begin
        chk($sformatf("rnd_rdata_s%0d", g_src), 32'(rd_of(g_src)), 32'(exp_rd[g_src]));
        act[g_src] = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
